// File: rtl/spart_bus_responder.sv
// spart_bus_responder: processor-side SPART bus responder with register file and baud generator
//   clk, rst            : clock and asynchronous active-high reset
//   iocs/iorw/ioaddr    : bus cycle select, direction (1 = read) and register address
//   databus             : shared bidirectional 8-bit data bus
//   rx_valid/rx_byte    : received byte strobe and data from the RX core
//   tx_done             : frame-finished strobe from the TX core
//   tx_start/tx_byte    : transmit start pulse and TX hold register
//   brg_en              : 16x-oversample baud enable
//   rda/tbr             : receive data available, transmit buffer ready
module spart_bus_responder #(
  parameter logic [15:0] DEFAULT_DIV = 16'd1301
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  input  logic       tx_done,
  output logic       tx_start,
  output logic [7:0] tx_byte,
  output logic       brg_en,
  output logic       rda,
  output logic       tbr
);
  logic [7:0] r_rx_buf, r_tx_byte, r_div_lo, r_div_hi;
  logic [15:0] r_cnt;
  logic r_rda, r_tbr, r_ovr, r_tx_start, r_brg_en;
  logic w_rd, w_wr, w_rd0, w_rd1, w_wr0, w_wr2, w_wr3, w_accept;
  logic [7:0] w_rdata;
  always_comb begin
    w_rd = iocs & iorw;
    w_wr = iocs & ~iorw;
    w_rd0 = w_rd & (ioaddr == 2'd0);
    w_rd1 = w_rd & (ioaddr == 2'd1);
    w_wr0 = w_wr & (ioaddr == 2'd0);
    w_wr2 = w_wr & (ioaddr == 2'd2);
    w_wr3 = w_wr & (ioaddr == 2'd3);
    w_accept = w_wr0 & r_tbr;
    w_rdata = ioaddr == 2'd0 ? r_rx_buf :
              ioaddr == 2'd1 ? {5'b0, r_ovr, r_tbr, r_rda} :
              ioaddr == 2'd2 ? r_div_lo : r_div_hi;
  end
  // Released during reset so a mid-cycle reset frees the bus immediately.
  assign databus = (w_rd & ~rst) ? w_rdata : 8'bz;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_byte  <= 8'h00;
      r_tbr      <= 1'b1;
      r_tx_start <= 1'b0;
    end else begin
      r_tx_start <= w_accept;
      if (w_accept) r_tx_byte <= databus;
      // An accepted write outranks a coincident tx_done.
      r_tbr <= w_accept ? 1'b0 : tx_done ? 1'b1 : r_tbr;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_buf <= 8'h00;
      r_rda    <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      if (rx_valid) r_rx_buf <= rx_byte;
      r_rda <= rx_valid ? 1'b1 : w_rd0 ? 1'b0 : r_rda;
      // Overrun only when the unread byte is not being consumed this cycle.
      r_ovr <= (rx_valid & r_rda & ~w_rd0) ? 1'b1 : w_rd1 ? 1'b0 : r_ovr;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_lo <= DEFAULT_DIV[7:0];
      r_div_hi <= DEFAULT_DIV[15:8];
      r_cnt    <= DEFAULT_DIV;
      r_brg_en <= 1'b0;
    end else begin
      if (w_wr2) r_div_lo <= databus;
      if (w_wr3) r_div_hi <= databus;
      // Writing the high byte restarts the count with the new divisor.
      r_cnt <= w_wr3 ? {databus, r_div_lo} : r_cnt == 16'd0 ? {r_div_hi, r_div_lo} : r_cnt - 16'd1;
      r_brg_en <= ~w_wr3 & (r_cnt == 16'd0);
    end
  end
  assign tx_start = r_tx_start;
  assign tx_byte  = r_tx_byte;
  assign brg_en   = r_brg_en;
  assign rda      = r_rda;
  assign tbr      = r_tbr;
endmodule

// File: tb/tb_spart_bus_responder.sv
// tb_spart_bus_responder: directed scoreboard bench for spart_bus_responder
module tb_spart_bus_responder;
  logic clk = 1'b0, rst = 1'b1, iocs = 1'b0, iorw = 1'b0, rx_valid = 1'b0, tx_done = 1'b0, drv_en = 1'b0;
  logic [1:0] ioaddr = 2'd0;
  logic [7:0] rx_byte = 8'h00, drv = 8'h00;
  wire [7:0] databus, tx_byte;
  wire tx_start, brg_en, rda, tbr;
  int checks = 0, failures = 0, tx_pulses = 0, n;
  logic [7:0] q_tx[$], q_rd[$];
  assign databus = drv_en ? drv : 8'bz;
  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (databus[i]);
  end
  spart_bus_responder dut (
    .clk(clk), .rst(rst), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr), .databus(databus),
    .rx_valid(rx_valid), .rx_byte(rx_byte), .tx_done(tx_done), .tx_start(tx_start),
    .tx_byte(tx_byte), .brg_en(brg_en), .rda(rda), .tbr(tbr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  always @(negedge clk) if (tx_start) begin
    tx_pulses++;
    chk("tx_queue", 16'(q_tx.size()), 16'd1);
    if (q_tx.size() != 0) chk("tx_byte_pulse", 16'(tx_byte), 16'(q_tx.pop_front()));
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    iocs = 1; iorw = 0; ioaddr = a; drv = d; drv_en = 1;
    cyc();
    iocs = 0; drv_en = 0;
  endtask
  task automatic rd(input string tag, input logic [1:0] a);
    iocs = 1; iorw = 1; ioaddr = a;
    #1 chk(tag, 16'(databus), 16'(q_rd.pop_front()));
    cyc();
    iocs = 0;
  endtask
  task automatic rxp(input logic [7:0] d);
    rx_valid = 1; rx_byte = d;
    cyc();
    rx_valid = 0;
  endtask
  task automatic wbrg(output int cnt);
    cnt = 0;
    for (int i = 1; i <= 70000; i++) begin
      cyc();
      if (brg_en) begin
        cnt = i;
        break;
      end
    end
  endtask
  initial begin
    repeat (3) cyc();
    chk("rst_tx_start", 16'(tx_start), 16'd0);
    chk("rst_tbr", 16'(tbr), 16'd1);
    chk("rst_rda", 16'(rda), 16'd0);
    chk("rst_brg_en", 16'(brg_en), 16'd0);
    chk("rst_tx_byte", 16'(tx_byte), 16'h00);
    chk("bus_idle", 16'(databus), 16'hff);
    rst = 0;
    wbrg(n); chk("brg_first", 16'(n), 16'd1302);
    wbrg(n); chk("brg_period", 16'(n), 16'd1302);
    q_rd.push_back(8'h02); rd("status_rst", 2'd1);
    iocs = 1; iorw = 0; ioaddr = 2'd1;
    #1 chk("bus_z_write", 16'(databus), 16'hff);
    cyc();
    iocs = 0;
    wr(2'd2, 8'h45);
    wr(2'd3, 8'h02);
    wbrg(n); chk("brg_div_first", 16'(n), 16'd582);
    wbrg(n); chk("brg_div_period", 16'(n), 16'd582);
    q_rd.push_back(8'h45); rd("div_lo", 2'd2);
    q_rd.push_back(8'h02); rd("div_hi", 2'd3);
    q_tx.push_back(8'hA5); wr(2'd0, 8'hA5);
    cyc();
    chk("tx_byte_a5", 16'(tx_byte), 16'hA5);
    q_rd.push_back(8'h00); rd("status_busy", 2'd1);
    wr(2'd0, 8'h3C);
    cyc();
    chk("tx_ignored", 16'(tx_byte), 16'hA5);
    chk("tx_pulses_1", 16'(tx_pulses), 16'd1);
    tx_done = 1; cyc(); tx_done = 0;
    q_rd.push_back(8'h02); rd("status_done", 2'd1);
    q_tx.push_back(8'h3C);
    iocs = 1; iorw = 0; ioaddr = 2'd0; drv = 8'h3C; drv_en = 1;
    repeat (3) cyc();
    iocs = 0; drv_en = 0;
    cyc();
    chk("tx_pulses_held", 16'(tx_pulses), 16'd2);
    chk("tx_byte_3c", 16'(tx_byte), 16'h3C);
    tx_done = 1; cyc(); tx_done = 0;
    rxp(8'h5A);
    q_rd.push_back(8'h03); rd("status_rx", 2'd1);
    iocs = 1; iorw = 1; ioaddr = 2'd0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("rd_held_bus", 16'(databus), 16'h5A);
      cyc();
      chk("rd_held_rda", 16'(rda), 16'd0);
    end
    iocs = 0;
    q_rd.push_back(8'h02); rd("status_consumed", 2'd1);
    rxp(8'h11);
    rxp(8'h22);
    q_rd.push_back(8'h07); rd("status_ovr", 2'd1);
    q_rd.push_back(8'h03); rd("status_ovr_clr", 2'd1);
    q_rd.push_back(8'h22); rd("rx_buf_22", 2'd0);
    q_rd.push_back(8'h02); rd("status_empty", 2'd1);
    rxp(8'h77);
    iocs = 1; iorw = 1; ioaddr = 2'd0; rx_valid = 1; rx_byte = 8'h88;
    #1 chk("coinc_bus", 16'(databus), 16'h77);
    cyc();
    rx_valid = 0; iocs = 0;
    chk("coinc_rda", 16'(rda), 16'd1);
    q_rd.push_back(8'h03); rd("coinc_status", 2'd1);
    q_rd.push_back(8'h88); rd("coinc_new", 2'd0);
    wr(2'd2, 8'h00);
    wr(2'd3, 8'h00);
    wbrg(n); chk("brg_div0_a", 16'(n), 16'd1);
    wbrg(n); chk("brg_div0_b", 16'(n), 16'd1);
    iocs = 1; iorw = 0; ioaddr = 2'd0; drv = 8'h99; drv_en = 1;
    #2 rst = 1;
    cyc(); cyc();
    chk("rstmid_tx_start", 16'(tx_start), 16'd0);
    chk("rstmid_tbr", 16'(tbr), 16'd1);
    chk("rstmid_tx_byte", 16'(tx_byte), 16'h00);
    chk("rstmid_brg_en", 16'(brg_en), 16'd0);
    drv_en = 0; iorw = 1;
    #1 chk("rstmid_bus", 16'(databus), 16'hff);
    iocs = 0; rst = 0;
    cyc();
    chk("rstmid_pulses", 16'(tx_pulses), 16'd2);
    chk("tx_queue_empty", 16'(q_tx.size()), 16'd0);
    q_rd.push_back(8'h02); rd("status_after_rst", 2'd1);
    q_rd.push_back(8'h00); rd("rx_buf_after_rst", 2'd0);
    q_rd.push_back(8'h15); rd("div_lo_after_rst", 2'd2);
    q_rd.push_back(8'h05); rd("div_hi_after_rst", 2'd3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spart_bus_responder.md
Name: spart_bus_responder

Overview:
Processor-side responder of the SPART bus. It decodes iocs/iorw/ioaddr cycles issued by the SPART driver and drives or samples the shared 8-bit databus. It holds the RX data and status registers, the TX hold register and the 16-bit baud divisor. It also contains the baud-rate generator that produces the 16x-oversample enable consumed by the SPART TX/RX cores.

Parameters:
DEFAULT_DIV, 16'd1301, divisor loaded at reset (4800 baud x16 at 100 MHz).

Ports:
clk  input  1  system clock, 100 MHz
rst  input  1  reset, asynchronous, active-high
iocs  input  1  chip select; bus cycle valid when 1
iorw  input  1  1 = read (responder drives databus), 0 = write
ioaddr  input  2  00 data, 01 status, 10 divisor low, 11 divisor high
databus  inout  8  shared bidirectional data bus
rx_valid  input  1  1-cycle pulse from RX core: new byte on rx_byte
rx_byte  input  8  received byte, valid with rx_valid
tx_done  input  1  1-cycle pulse from TX core: frame finished
tx_start  output  1  registered 1-cycle pulse: start transmitting tx_byte
tx_byte  output  8  TX hold register
brg_en  output  1  registered 1-cycle baud enable (16x baud)
rda  output  1  receive data available
tbr  output  1  transmit buffer ready

Behaviour:
- Reset values (async): rda=0, tbr=1, ovr=0, tx_start=0, tx_byte=0, rx_buf=0, brg_en=0, div_lo/div_hi=DEFAULT_DIV, baud counter=DEFAULT_DIV; databus released (Z).
- Databus drive: combinational; drive only when iocs=1 and iorw=1, otherwise 8'bz. Read mux:
  - 00: rx_buf
  - 01: {5'b0, ovr, tbr, rda}
  - 10: div_lo
  - 11: div_hi
- Reads of 10/11 have no side effects.
- Register updates occur at the clk edge ending each cycle with iocs=1. Multi-cycle cycles (the same access held for N clocks) must behave as if they occurred once.
- Write 00 (iorw=0): if tbr=1, tx_byte<=databus, tbr<=0, tx_start=1 on the next cycle only. If tbr=0, the write is ignored: tx_byte is unchanged and no pulse is issued. A held write produces one tx_start, because tbr is already 0.
- tx_done pulse: tbr<=1. If tx_done coincides with an accepted write, the write wins and tbr stays 0.
- Write 10: div_lo<=databus; the counter is unaffected.
- Write 11: div_hi<=databus; the counter reloads with {databus, div_lo} at the same edge; brg_en=0 that cycle.
- Write 01: ignored.
- Read 00: rda<=0 at every edge of the cycle. The driver samples rx_buf during the cycle.
- rx_valid: rx_buf<=rx_byte, rda<=1.
  - If rda=1 and no read 00 occurs that cycle, ovr<=1; the byte is still overwritten.
  - If rx_valid coincides with a read 00, the new byte wins: rda stays 1, ovr is unchanged, and the bus shows the old rx_buf that cycle.
- Read 01: ovr<=0 at the edge. If rx_valid causes an overrun in the same cycle, ovr stays 1.
- Baud generator: 16-bit down counter.
  - If cnt==0: brg_en<=1, cnt<={div_hi,div_lo}.
  - Otherwise: brg_en<=0, cnt<=cnt-1.
  - Enable period = divisor+1 clocks.
  - Divisor 0 gives brg_en=1 every cycle; divisor FFFF gives a period of 65536 clocks, with no overflow.
- iocs=0: no register changes from the bus; rx_valid, tx_done and the baud counter still operate.
- Reset mid-cycle: all state returns to reset values immediately; databus released; a pending tx_start is cancelled.

Test Plan:
- Reset, then no bus activity -> brg_en pulses every 1302 clocks; status read returns 8'h02; databus Z whenever iocs=0 or iorw=0.
- Write 10 = 8'h45, then 11 = 8'h02 (div 581) -> counter reloads at the high write; next brg_en exactly 582 clocks later, then every 582; readback 10=8'h45, 11=8'h02.
- Write 00 = 8'hA5 with tbr=1 -> tx_byte=A5 and a single tx_start pulse, tbr=0. A second write of 8'h3C before tx_done is ignored (tx_byte stays A5). After tx_done, tbr=1.
- rx_valid with 8'h5A -> rda=1; read 00 held 3 cycles -> databus=5A throughout, rda=0 after the first edge, one byte consumed.
- Two rx_valid (11, 22) without a read -> rx_buf=22, status=8'h07; status read -> returns 07, next status read returns 03.
- rx_valid coincident with read 00 -> bus shows old byte, rda stays 1, ovr stays 0. Assert rst during a held write 00 -> no tx_start, tbr=1, databus Z.
